// File: rtl/collatz_pkg.sv
// rtl/collatz_pkg.sv - shared widths and sweep state encoding for the Collatz sweep controller
package collatz_pkg;

   localparam int BITS      = 32;
   localparam int CNT_BITS  = 16;
   localparam int WDOG_BITS = 20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_UPDATE,
      ST_FINISH
   } sweep_state_t;

endpackage

// File: rtl/collatz_best_tracker.sv
// rtl/collatz_best_tracker.sv - running maximum of one value with the seed that produced it
// Strict greater-than, so on a tie the earlier seed is kept.
module collatz_best_tracker #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_val,
   input  logic [W-1:0] i_seed,
   output logic [W-1:0] o_val,
   output logic [W-1:0] o_seed
);

   logic [W-1:0] r_val;
   logic [W-1:0] r_seed;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_val  <= '0;
         r_seed <= '0;
      end else if (i_en && (i_val > r_val)) begin
         r_val  <= i_val;
         r_seed <= i_seed;
      end
   end

   assign o_val  = r_val;
   assign o_seed = r_seed;

endmodule

// File: rtl/collatz_sweep_ctrl.sv
// rtl/collatz_sweep_ctrl.sv - sweeps consecutive seeds through the Collatz engine and keeps the maxima
// One launch per seed, per-seed watchdog, abort path back to IDLE.
module collatz_sweep_ctrl #(
   parameter int BITS      = collatz_pkg::BITS,
   parameter int CNT_BITS  = collatz_pkg::CNT_BITS,
   parameter int WDOG_BITS = collatz_pkg::WDOG_BITS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [BITS-1:0]     i_cfg_start,
   input  logic [CNT_BITS-1:0] i_cfg_count,
   input  logic                i_go,
   input  logic                i_abort,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_core_start,
   output logic                o_core_abort,
   output logic [BITS-1:0]     o_core_seed,
   input  logic                i_core_done,
   input  logic [BITS-1:0]     i_core_orbit_len,
   input  logic [BITS-1:0]     i_core_peak,
   output logic [BITS-1:0]     o_best_len,
   output logic [BITS-1:0]     o_best_seed,
   output logic [BITS-1:0]     o_peak_val,
   output logic [BITS-1:0]     o_peak_seed,
   output logic [CNT_BITS-1:0] o_seeds_done,
   output logic [CNT_BITS-1:0] o_timeout_cnt,
   output logic                o_wrapped
);
   import collatz_pkg::*;

   // Last count value before the limit: the limit-th WAIT cycle is the one that times out.
   localparam logic [WDOG_BITS-1:0] WDOG_LAST = ~WDOG_BITS'(1);

   sweep_state_t         r_state;
   sweep_state_t         w_next_state;
   logic [BITS-1:0]      r_seed;
   logic [BITS-1:0]      r_len;
   logic [BITS-1:0]      r_peak;
   logic [CNT_BITS-1:0]  r_remaining;
   logic [CNT_BITS-1:0]  r_seeds_done;
   logic [CNT_BITS-1:0]  r_timeout_cnt;
   logic [CNT_BITS-1:0]  w_rem_dec;
   logic [WDOG_BITS-1:0] r_wdog;
   logic                 r_fold;
   logic                 r_wrapped;
   logic                 r_core_abort;
   logic                 w_accept;
   logic                 w_timeout;
   logic                 w_seed_zero;
   logic                 w_seed_last;
   logic                 w_fold_en;

   assign w_accept    = (r_state == ST_IDLE) && i_go && !i_abort;
   assign w_timeout   = (r_state == ST_WAIT) && !i_core_done && (r_wdog == WDOG_LAST);
   assign w_seed_zero = (r_seed == '0);
   assign w_seed_last = (r_seed == '1);
   assign w_rem_dec   = r_remaining - 1'b1;
   assign w_fold_en   = (r_state == ST_UPDATE) && r_fold && !i_abort;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_next_state = (i_cfg_count == '0) ? ST_FINISH : ST_LAUNCH;
         ST_LAUNCH: w_next_state = w_seed_zero ? ST_UPDATE : ST_WAIT;
         ST_WAIT:   if (i_core_done || w_timeout) w_next_state = ST_UPDATE;
         ST_UPDATE: w_next_state = ((w_rem_dec == '0) || w_seed_last) ? ST_FINISH : ST_LAUNCH;
         ST_FINISH: w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
      if (i_abort && (r_state != ST_IDLE)) w_next_state = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_seed        <= '0;
         r_len         <= '0;
         r_peak        <= '0;
         r_remaining   <= '0;
         r_seeds_done  <= '0;
         r_timeout_cnt <= '0;
         r_wdog        <= '0;
         r_fold        <= 1'b0;
         r_wrapped     <= 1'b0;
         r_core_abort  <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_core_abort <= (r_state == ST_WAIT) && (i_abort || w_timeout);
         r_fold       <= 1'b0;
         if (w_accept) begin
            r_seed        <= i_cfg_start;
            r_remaining   <= i_cfg_count;
            r_seeds_done  <= '0;
            r_timeout_cnt <= '0;
            r_wrapped     <= 1'b0;
         end else if (!i_abort) begin
            case (r_state)
               ST_LAUNCH: r_wdog <= '0;
               ST_WAIT: begin
                  r_wdog <= r_wdog + 1'b1;
                  // Engine outputs are only valid with core_done, so hold them for UPDATE.
                  if (i_core_done) begin
                     r_len  <= i_core_orbit_len;
                     r_peak <= i_core_peak;
                     r_fold <= 1'b1;
                  end else if (w_timeout) begin
                     r_timeout_cnt <= r_timeout_cnt + 1'b1;
                  end
               end
               ST_UPDATE: begin
                  r_seeds_done <= r_seeds_done + 1'b1;
                  r_remaining  <= w_rem_dec;
                  if (w_rem_dec != '0) begin
                     if (w_seed_last) r_wrapped <= 1'b1;
                     else             r_seed    <= r_seed + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   collatz_best_tracker #(.W(BITS)) u_len_tracker (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (w_accept),
      .i_en   (w_fold_en),
      .i_val  (r_len),
      .i_seed (r_seed),
      .o_val  (o_best_len),
      .o_seed (o_best_seed)
   );

   collatz_best_tracker #(.W(BITS)) u_peak_tracker (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (w_accept),
      .i_en   (w_fold_en),
      .i_val  (r_peak),
      .i_seed (r_seed),
      .o_val  (o_peak_val),
      .o_seed (o_peak_seed)
   );

   assign o_busy        = (r_state != ST_IDLE);
   assign o_done        = (r_state == ST_FINISH) && !i_abort;
   assign o_core_start  = (r_state == ST_LAUNCH) && !w_seed_zero && !i_abort;
   assign o_core_abort  = r_core_abort;
   assign o_core_seed   = r_seed;
   assign o_seeds_done  = r_seeds_done;
   assign o_timeout_cnt = r_timeout_cnt;
   assign o_wrapped     = r_wrapped;

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// tb/tb_collatz_sweep_ctrl.sv - scoreboard bench with a behavioural Collatz engine and sweep model
module tb_collatz_sweep_ctrl;

   localparam int BITS       = 32;
   localparam int CNT_BITS   = 16;
   localparam int WDOG_BITS  = 6;
   localparam int WDOG_LIMIT = (1 << WDOG_BITS) - 1;

   typedef struct {
      logic [BITS-1:0] best_len;
      logic [BITS-1:0] best_seed;
      logic [BITS-1:0] peak_val;
      logic [BITS-1:0] peak_seed;
      int              seeds_done;
      int              timeouts;
      bit              wrapped;
   } summ_t;

   logic                clk = 1'b0;
   logic                reset;
   logic [BITS-1:0]     cfg_start;
   logic [CNT_BITS-1:0] cfg_count;
   logic                go, abort;
   logic                busy, done, core_start, core_abort;
   logic [BITS-1:0]     core_seed;
   logic                core_done;
   logic [BITS-1:0]     core_orbit_len, core_peak;
   logic [BITS-1:0]     best_len, best_seed, peak_val, peak_seed;
   logic [CNT_BITS-1:0] seeds_done, timeout_cnt;
   logic                wrapped;

   int      n_checks = 0;
   int      n_pass = 0;
   int      eng_mode = 0;
   int      done_cnt = 0;
   int      kill_cnt = 0;
   longint  cyc = 0;
   longint  last_start_cyc = 0;
   longint  last_kill_dist = 0;
   logic [BITS-1:0] launch_q[$];
   summ_t   exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   collatz_sweep_ctrl #(.BITS(BITS), .CNT_BITS(CNT_BITS), .WDOG_BITS(WDOG_BITS)) dut (
      .clk              (clk),
      .reset            (reset),
      .i_cfg_start      (cfg_start),
      .i_cfg_count      (cfg_count),
      .i_go             (go),
      .i_abort          (abort),
      .o_busy           (busy),
      .o_done           (done),
      .o_core_start     (core_start),
      .o_core_abort     (core_abort),
      .o_core_seed      (core_seed),
      .i_core_done      (core_done),
      .i_core_orbit_len (core_orbit_len),
      .i_core_peak      (core_peak),
      .o_best_len       (best_len),
      .o_best_seed      (best_seed),
      .o_peak_val       (peak_val),
      .o_peak_seed      (peak_seed),
      .o_seeds_done     (seeds_done),
      .o_timeout_cnt    (timeout_cnt),
      .o_wrapped        (wrapped)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic void collatz(input logic [BITS-1:0] seed,
                                   output logic [BITS-1:0] len, output logic [BITS-1:0] pk);
      longint unsigned v = seed;
      longint unsigned p = seed;
      int n = 0;
      while (v > 1 && n < 10000) begin
         if (v % 2 == 1) v = 3 * v + 1;
         else            v = v / 2;
         if (v > p) p = v;
         n++;
      end
      len = BITS'(n);
      pk  = p[BITS-1:0];
   endfunction

   // Reference sweep: walk the seed range with plain arithmetic, stop past 2**BITS-1.
   function automatic void model(input logic [BITS-1:0] st, input int cnt, input int mode);
      summ_t e;
      longint unsigned s = st;
      logic [BITS-1:0] l, p;
      e = '{default: 0};
      for (int i = 0; i < cnt; i++) begin
         if (s > 64'hFFFF_FFFF) begin
            e.wrapped = 1;
            break;
         end
         e.seeds_done++;
         if (s != 0) begin
            launch_q.push_back(s[BITS-1:0]);
            if (mode == 1) e.timeouts++;
            else begin
               collatz(s[BITS-1:0], l, p);
               if (l > e.best_len) begin e.best_len = l; e.best_seed = s[BITS-1:0]; end
               if (p > e.peak_val) begin e.peak_val = p; e.peak_seed = s[BITS-1:0]; end
            end
         end
         s++;
      end
      exp_q.push_back(e);
   endfunction

   // Engine: mode 0 random latency 1..5, mode 1 never answers, mode 2 latency 30.
   initial begin : engine
      core_done = 1'b0;
      core_orbit_len = '0;
      core_peak = '0;
      forever begin
         @(negedge clk);
         if (core_start && !reset && eng_mode != 1) begin
            automatic logic [BITS-1:0] s = core_seed;
            automatic int lat = (eng_mode == 2) ? 30 : int'($urandom_range(1, 5));
            automatic bit killed = 1'b0;
            for (int i = 0; i < lat; i++) begin
               @(posedge clk); #1;
               if (core_abort || reset) killed = 1'b1;
            end
            if (!killed) begin
               collatz(s, core_orbit_len, core_peak);
               core_done = 1'b1;
               @(posedge clk); #1;
               core_done = 1'b0;
            end
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (core_start) begin
               last_start_cyc = cyc;
               if (launch_q.size() == 0) check("unexpected_core_start", core_start, 0);
               else check("core_seed", core_seed, launch_q.pop_front());
            end
            if (core_abort) begin
               kill_cnt++;
               last_kill_dist = cyc - last_start_cyc;
            end
            if (done) begin
               done_cnt++;
               if (exp_q.size() == 0) check("unexpected_done", done, 0);
               else begin
                  automatic summ_t e = exp_q.pop_front();
                  check("best_len", best_len, e.best_len);
                  check("best_seed", best_seed, e.best_seed);
                  check("peak_val", peak_val, e.peak_val);
                  check("peak_seed", peak_seed, e.peak_seed);
                  check("seeds_done", seeds_done, e.seeds_done);
                  check("timeout_cnt", timeout_cnt, e.timeouts);
                  check("wrapped", wrapped, e.wrapped);
                  check("launches_outstanding", launch_q.size(), 0);
               end
            end
         end
      end
   end

   task automatic run_sweep(input logic [BITS-1:0] st, input int cnt, input int mode, input bit poke);
      int d0;
      int n;
      int budget;
      eng_mode = mode;
      model(st, cnt, mode);
      d0 = done_cnt;
      cfg_start = st;
      cfg_count = CNT_BITS'(cnt);
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      budget = cnt * (WDOG_LIMIT + 8) + 20;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         if (poke && n == 6) begin
            cfg_start = 100;
            cfg_count = 1;
            go = 1'b1;
         end else go = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      go = 1'b0;
      check("sweep_completes", done_cnt - d0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin : stimulus
      int k0;
      int d0;
      int n;
      reset = 1'b1;
      go = 1'b0;
      abort = 1'b0;
      cfg_start = '0;
      cfg_count = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_core_start", core_start, 0);
      check("rst_core_abort", core_abort, 0);
      check("rst_core_seed", core_seed, 0);
      check("rst_best_len", best_len, 0);
      check("rst_best_seed", best_seed, 0);
      check("rst_peak_val", peak_val, 0);
      check("rst_peak_seed", peak_seed, 0);
      check("rst_seeds_done", seeds_done, 0);
      check("rst_timeout_cnt", timeout_cnt, 0);
      check("rst_wrapped", wrapped, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      go = 1'b1; abort = 1'b1; cfg_start = 5; cfg_count = 1;
      @(posedge clk); #1;
      go = 1'b0; abort = 1'b0;
      check("go_with_abort_ignored", busy, 0);

      run_sweep(27, 1, 0, 0);
      check("s27_best_len", best_len, 111);
      check("s27_best_seed", best_seed, 27);
      check("s27_peak_val", peak_val, 9232);
      check("s27_seeds_done", seeds_done, 1);

      run_sweep(1, 10, 0, 1);
      check("s1_best_seed", best_seed, 9);
      check("s1_best_len", best_len, 19);
      check("s1_peak_seed", peak_seed, 7);
      check("s1_peak_val", peak_val, 52);
      check("s1_seeds_done", seeds_done, 10);

      run_sweep(0, 3, 0, 0);
      check("s0_seeds_done", seeds_done, 3);

      run_sweep(32'hFFFF_FFFE, 5, 0, 0);
      check("wrap_flag", wrapped, 1);
      check("wrap_seeds_done", seeds_done, 2);

      k0 = kill_cnt;
      run_sweep(5, 2, 1, 0);
      check("wdog_timeouts", timeout_cnt, 2);
      check("wdog_kills", kill_cnt - k0, 2);
      check("wdog_latency", last_kill_dist, WDOG_LIMIT + 1);

      // Abort while seed 3 is in flight.
      eng_mode = 2;
      launch_q.push_back(1); launch_q.push_back(2); launch_q.push_back(3);
      k0 = kill_cnt;
      d0 = done_cnt;
      cfg_start = 1; cfg_count = 10; go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      n = 0;
      while (!(core_start && core_seed == 3) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort_seed3_launched", core_start, 1);
      repeat (2) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_idle", busy, 0);
      check("abort_core_abort", core_abort, 1);
      check("abort_seeds_done", seeds_done, 2);
      check("abort_best_len", best_len, 1);
      check("abort_best_seed", best_seed, 2);
      check("abort_peak_seed", peak_seed, 2);
      repeat (40) @(posedge clk);
      #1;
      check("abort_kill_count", kill_cnt - k0, 1);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_launches", launch_q.size(), 0);

      run_sweep(77, 0, 0, 0);
      check("cnt0_idle", busy, 0);

      for (int i = 0; i < 6; i++)
         run_sweep(BITS'($urandom_range(0, 300)), int'($urandom_range(1, 12)), 0, 0);
      run_sweep(32'hFFFF_FFFF - BITS'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 0, 0);

      // Reset mid-sweep: back to reset values with no engine kill.
      eng_mode = 2;
      launch_q.push_back(1);
      k0 = kill_cnt;
      cfg_start = 1; cfg_count = 4; go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("rstmid_busy", busy, 0);
      check("rstmid_core_seed", core_seed, 0);
      check("rstmid_core_abort", core_abort, 0);
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("rstmid_no_kill", kill_cnt - k0, 0);
      check("rstmid_launches", launch_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : global_bound
      #3000000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
